// File: rtl/rf_wb_scheduler.sv
`timescale 1ns/1ps
// rf_wb_scheduler: shares the register file's single write port among NREQ
// write-back sources using round-robin arbitration. It also keeps a per-register
// pending-write scoreboard that decode uses to detect RAW hazards.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   wb_req/wb_rd/wb_data         per-source write-back requests (rd at [5i+:5], data at [32i+:32])
//   wb_gnt                       one-hot grant (combinational)
//   rf_we/rf_waddr/rf_wdata      register-file write port (combinational)
//   iss_valid/iss_rd/iss_ready   decode issue of an instruction writing iss_rd
//   chk_rs1/chk_rs2              source indices checked by decode
//   busy_rs1/busy_rs2            source still has an uncommitted pending write
//   flush                        synchronous clear of the scoreboard and rr pointer
module rf_wb_scheduler #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      wb_req,
    input  logic [5*NREQ-1:0]    wb_rd,
    input  logic [32*NREQ-1:0]   wb_data,
    output logic [NREQ-1:0]      wb_gnt,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_rd,
    output logic                 iss_ready,
    input  logic [4:0]           chk_rs1,
    input  logic [4:0]           chk_rs2,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    input  logic                 flush
);

    localparam int unsigned RR_W   = $clog2(NREQ);
    localparam int unsigned NREGS  = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [RR_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];

    logic             found;
    logic [NREQ-1:0]  gnt_raw;
    logic [RR_W:0]    sum;
    logic [RR_W-1:0]  win;
    logic [4:0]       win_rd;
    logic [31:0]      win_data;
    logic             gnt_any;
    logic             inc;
    logic [CNT_W-1:0] iss_cnt, chk1_cnt, chk2_cnt;

    // Round-robin search starting at rr_q, wrapping at NREQ.
    always_comb begin
        found   = 1'b0;
        gnt_raw = '0;
        sum     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_q} + (RR_W+1)'(k);
            if (sum >= (RR_W+1)'(NREQ)) begin
                sum = sum - (RR_W+1)'(NREQ);
            end
            if (!found && wb_req[sum[RR_W-1:0]]) begin
                found   = 1'b1;
                gnt_raw = NREQ'(1) << sum[RR_W-1:0];
            end
        end
    end

    // Winner index and field mux.
    always_comb begin
        win      = '0;
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_raw[i]) begin
                win      = RR_W'(i);
                win_rd   = wb_rd[5*i +: 5];
                win_data = wb_data[32*i +: 32];
            end
        end
    end

    // Write port; everything is forced idle while reset is held low.
    assign gnt_any  = reset && found;
    assign wb_gnt   = gnt_any ? gnt_raw : '0;
    assign rf_we    = gnt_any && (win_rd != 5'd0);
    assign rf_waddr = gnt_any ? win_rd : 5'd0;
    assign rf_wdata = gnt_any ? win_data : 32'd0;

    // Issue is refused only when the target counter is full and not draining this cycle.
    assign iss_cnt   = cnt_q[iss_rd];
    assign iss_ready = !(reset && iss_valid && (iss_rd != 5'd0) && (iss_cnt == CNT_MAX)
                         && !(rf_we && (rf_waddr == iss_rd)));
    assign inc       = iss_valid && iss_ready && (iss_rd != 5'd0);

    // Busy with write-through: a final pending write committing now clears busy.
    assign chk1_cnt = cnt_q[chk_rs1];
    assign chk2_cnt = cnt_q[chk_rs2];
    assign busy_rs1 = reset && (chk_rs1 != 5'd0) && (chk1_cnt != '0)
                      && !(rf_we && (rf_waddr == chk_rs1) && (chk1_cnt == CNT_W'(1)));
    assign busy_rs2 = reset && (chk_rs2 != 5'd0) && (chk2_cnt != '0)
                      && !(rf_we && (rf_waddr == chk_rs2) && (chk2_cnt == CNT_W'(1)));

    // Next-state counters; x0 stays at zero, flush wins over inc/dec.
    always_comb begin
        for (int r = 0; r < int'(NREGS); r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0 || flush) begin
                cnt_d[r] = '0;
            end else if (inc && (iss_rd == 5'(r)) && !(rf_we && (rf_waddr == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (rf_we && (rf_waddr == 5'(r)) && !(inc && (iss_rd == 5'(r)))
                         && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Pointer advances past the winner on any grant.
    always_comb begin
        rr_d = rr_q;
        if (flush) begin
            rr_d = '0;
        end else if (gnt_any) begin
            rr_d = (win == RR_W'(NREQ-1)) ? '0 : win + RR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= '0;
            for (int r = 0; r < int'(NREGS); r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int r = 0; r < int'(NREGS); r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
`timescale 1ns/1ps
// Testbench for rf_wb_scheduler: directed scenarios plus random traffic checked
// by a scoreboard against a behavioural model of the arbiter and pending counters.
module tb_rf_wb_scheduler;

    localparam int NREQ = 3;
    localparam int CNT_W = 2;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      wb_req;
    logic [5*NREQ-1:0]    wb_rd;
    logic [32*NREQ-1:0]   wb_data;
    logic [NREQ-1:0]      wb_gnt;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic                 iss_valid;
    logic [4:0]           iss_rd;
    logic                 iss_ready;
    logic [4:0]           chk_rs1, chk_rs2;
    logic                 busy_rs1, busy_rs2;
    logic                 flush;

    rf_wb_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data), .wb_gnt(wb_gnt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            we;
        logic [4:0]      waddr;
        logic [31:0]     wdata;
        logic            rdy;
        logic            b1;
        logic            b2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    int          cnt_m [32];
    int          rr_m;
    bit          pend [NREQ];
    logic [4:0]  prd  [NREQ];
    logic [31:0] pdat [NREQ];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit busy_m(input logic [4:0] c, input bit we, input logic [4:0] wa);
        int n;
        n = cnt_m[c] - ((we && wa == c) ? 1 : 0);
        return (c != 5'd0) && (n > 0);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        rr_m = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            prd[i]  = 5'd0;
            pdat[i] = 32'd0;
        end
    endtask

    task automatic drive_pins();
        for (int i = 0; i < NREQ; i++) begin
            wb_req[i]         = pend[i];
            wb_rd[5*i +: 5]   = prd[i];
            wb_data[32*i +: 32] = pdat[i];
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        chk_rs1   = 5'd0;
        chk_rs2   = 5'd0;
        flush     = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
        pend[i] = 1'b1;
        prd[i]  = rd;
        pdat[i] = d;
    endtask

    // Drive one cycle: predict outputs, queue them, advance the model to the next edge.
    task automatic run_cycle(input bit fl);
        exp_t e;
        bit   found;
        int   win;
        bit   incr;
        flush = fl;
        drive_pins();
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && pend[(rr_m + k) % NREQ]) begin
                found = 1'b1;
                win   = (rr_m + k) % NREQ;
            end
        end
        e.gnt   = found ? (NREQ'(1) << win) : '0;
        e.we    = found && (prd[win] != 5'd0);
        e.waddr = found ? prd[win] : 5'd0;
        e.wdata = found ? pdat[win] : 32'd0;
        e.rdy   = !(iss_valid && iss_rd != 5'd0 && cnt_m[iss_rd] == MAXC
                    && !(e.we && e.waddr == iss_rd));
        e.b1    = busy_m(chk_rs1, e.we, e.waddr);
        e.b2    = busy_m(chk_rs2, e.we, e.waddr);
        exp_q.push_back(e);

        if (found) begin
            pend[win] = 1'b0;
            rr_m = (win + 1) % NREQ;
        end
        incr = iss_valid && e.rdy && (iss_rd != 5'd0);
        if (fl) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
            rr_m = 0;
        end else if (!(incr && e.we && iss_rd == e.waddr)) begin
            if (incr) cnt_m[iss_rd] = cnt_m[iss_rd] + 1;
            if (e.we && cnt_m[e.waddr] > 0) cnt_m[e.waddr] = cnt_m[e.waddr] - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(wb_gnt),   32'd0);
        check({tag, "_we"},    32'(rf_we),    32'd0);
        check({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
        check({tag, "_wdata"}, rf_wdata,      32'd0);
        check({tag, "_rdy"},   32'(iss_ready), 32'd1);
        check({tag, "_b1"},    32'(busy_rs1), 32'd0);
        check({tag, "_b2"},    32'(busy_rs2), 32'd0);
    endtask

    // Monitor: compare every queued expectation away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt",   32'(wb_gnt),    32'(e.gnt));
                check("we",    32'(rf_we),     32'(e.we));
                check("waddr", 32'(rf_waddr),  32'(e.waddr));
                check("wdata", rf_wdata,       e.wdata);
                check("ready", 32'(iss_ready), 32'(e.rdy));
                check("busy1", 32'(busy_rs1),  32'(e.b1));
                check("busy2", 32'(busy_rs2),  32'(e.b2));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with busy inputs: outputs must sit at reset values.
        reset     = 1'b0;
        wb_req    = '1;
        wb_rd     = {5'd7, 5'd6, 5'd5};
        wb_data   = '1;
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        chk_rs1   = 5'd3;
        chk_rs2   = 5'd5;
        flush     = 1'b0;
        #3;
        check_reset_outputs("in_reset");
        model_reset();
        idle_inputs();
        drive_pins();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Idle cycle after reset.
        run_cycle(1'b0);

        // Round-robin fairness: all requesting, grants 0,1,2,0,1,2.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 5'(5 + i), 32'(32'h100 * (c + 1) + i));
            run_cycle(1'b0);
        end

        // Scoreboard hazard on r9 with write-through clear.
        issue(5'd9);
        run_cycle(1'b0);
        idle_inputs();
        chk_rs1 = 5'd9;
        run_cycle(1'b0);
        set_req(1, 5'd9, 32'h0000_0909);
        run_cycle(1'b0);
        run_cycle(1'b0);

        // Counter saturation on r3.
        idle_inputs();
        chk_rs2 = 5'd3;
        for (int c = 0; c < 4; c++) begin
            issue(5'd3);
            run_cycle(1'b0);
        end
        issue(5'd3);
        set_req(0, 5'd3, 32'h3333_3333);
        run_cycle(1'b0);
        idle_inputs();
        chk_rs2 = 5'd3;
        run_cycle(1'b0);

        // x0 handling.
        issue(5'd0);
        chk_rs1 = 5'd0;
        set_req(2, 5'd0, 32'hDEAD_BEEF);
        run_cycle(1'b0);
        idle_inputs();
        run_cycle(1'b0);

        // Flush with r4 = 2, r8 = 1; grant search then restarts at source 0.
        issue(5'd4);
        run_cycle(1'b0);
        run_cycle(1'b0);
        issue(5'd8);
        run_cycle(1'b0);
        idle_inputs();
        chk_rs1 = 5'd4;
        chk_rs2 = 5'd8;
        run_cycle(1'b0);
        set_req(0, 5'd12, 32'h1212_1212);
        run_cycle(1'b1);
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(20 + i), 32'(32'hF0 + i));
        run_cycle(1'b0);
        for (int c = 0; c < 3; c++) run_cycle(1'b0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 5'($urandom_range(0, 15)), $urandom);
            end
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = 5'($urandom_range(0, 15));
            chk_rs1   = 5'($urandom_range(0, 15));
            chk_rs2   = 5'($urandom_range(0, 15));
            run_cycle($urandom_range(0, 49) == 0);
        end

        // Mid-stream asynchronous reset with pending state.
        idle_inputs();
        issue(5'd10);
        run_cycle(1'b0);
        idle_inputs();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(10 + i), 32'hA5A5_0000 + 32'(i));
        drive_pins();
        iss_valid = 1'b1;
        iss_rd    = 5'd10;
        chk_rs1   = 5'd10;
        chk_rs2   = 5'd11;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        model_reset();
        idle_inputs();
        drive_pins();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_rs1 = 5'd10;
        run_cycle(1'b0);
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(13 + i), 32'(32'h55 + i));
        run_cycle(1'b0);
        run_cycle(1'b0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
